updown_pulse_gen: RTL and testbench

Input-conditioning stage placed directly upstream of the up/down BCD counter. It turns two raw push-buttons and an auto-run switch into clean count requests: a single-cycle `count_tick` and a level `countSelect` (1 = up, 0 = down). Both outputs wire straight to the counter's count-enable and direction inputs. Buttons are synchronized and debounced. In auto mode a prescaler issues periodic ticks.

---
 rtl/updown_pulse_gen_if.sv | 25 ++
 rtl/updown_pulse_gen.sv | 144 ++++++++++++++
 tb/tb_updown_pulse_gen.sv | 123 ++++++++++++
 3 files changed

// File: rtl/updown_pulse_gen_if.sv
// Button/switch inputs and count-request outputs between the front panel and
// the up/down counter; master drives the raw inputs, slave is the conditioner.
interface updown_pulse_gen_if;
    logic btn_up;
    logic btn_down;
    logic auto_run;
    logic count_tick;
    logic countSelect;

    modport master (
        output btn_up,
        output btn_down,
        output auto_run,
        input  count_tick,
        input  countSelect
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        input  auto_run,
        output count_tick,
        output countSelect
    );
endinterface

// File: rtl/updown_pulse_gen.sv
// Synchronizes and debounces two push-buttons plus an auto-run switch and
// turns them into a one-cycle count tick and a registered count direction.
module updown_pulse_gen #(
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned DIV       = 50_000_000
) (
    input  logic              clk,
    input  logic              clc,
    updown_pulse_gen_if.slave bus
);

    localparam int unsigned CW = $clog2(DB_CYCLES + 1);
    localparam int unsigned PW = $clog2(DIV);
    localparam logic [CW-1:0] DB_MAX   = CW'(DB_CYCLES);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        S_LOW,
        P_HIGH,
        S_HIGH,
        P_LOW
    } db_state_t;

    // bit 0 = up, bit 1 = down, bit 2 = auto_run
    logic [2:0] sync1;
    logic [2:0] sync2;

    db_state_t     db_state [2];
    db_state_t     db_state_next [2];
    logic [CW-1:0] db_cnt [2];
    logic [CW-1:0] db_cnt_next [2];
    logic [1:0]    press;

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic          manual;
    logic          terminal;
    logic          tick_q;
    logic          tick_next;
    logic          sel_q;
    logic          sel_next;

    always_ff @(posedge clk) begin
        if (clc) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {bus.auto_run, bus.btn_down, bus.btn_up};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 2; i++) begin
            if (clc) begin
                db_state[i] <= S_LOW;
                db_cnt[i]   <= '0;
            end else begin
                db_state[i] <= db_state_next[i];
                db_cnt[i]   <= db_cnt_next[i];
            end
        end
    end

    // Pending states count agreeing samples; a disagreeing sample falls back
    // to the stable state it came from.
    always_comb begin
        press = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            db_state_next[i] = db_state[i];
            db_cnt_next[i]   = db_cnt[i];
            case (db_state[i])
                S_LOW: begin
                    if (sync2[i]) begin
                        db_state_next[i] = P_HIGH;
                        db_cnt_next[i]   = CW'(1);
                    end
                end
                P_HIGH: begin
                    if (!sync2[i]) begin
                        db_state_next[i] = S_LOW;
                        db_cnt_next[i]   = '0;
                    end else if (db_cnt[i] == DB_MAX) begin
                        db_state_next[i] = S_HIGH;
                        db_cnt_next[i]   = '0;
                        press[i]         = 1'b1;
                    end else begin
                        db_cnt_next[i] = db_cnt[i] + CW'(1);
                    end
                end
                S_HIGH: begin
                    if (!sync2[i]) begin
                        db_state_next[i] = P_LOW;
                        db_cnt_next[i]   = CW'(1);
                    end
                end
                P_LOW: begin
                    if (sync2[i]) begin
                        db_state_next[i] = S_HIGH;
                        db_cnt_next[i]   = '0;
                    end else if (db_cnt[i] == DB_MAX) begin
                        db_state_next[i] = S_LOW;
                        db_cnt_next[i]   = '0;
                    end else begin
                        db_cnt_next[i] = db_cnt[i] + CW'(1);
                    end
                end
                default: begin
                    db_state_next[i] = S_LOW;
                    db_cnt_next[i]   = '0;
                end
            endcase
        end
    end

    // A lone manual strobe beats a coincident terminal count and restarts the
    // prescaler; simultaneous up/down strobes cancel each other.
    always_comb begin
        manual     = press[0] ^ press[1];
        terminal   = sync2[2] && (presc == PRE_LAST);
        tick_next  = manual | terminal;
        sel_next   = manual ? press[0] : sel_q;
        presc_next = presc + PW'(1);
        if (!sync2[2] || manual || terminal) begin
            presc_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (clc) begin
            presc  <= '0;
            tick_q <= 1'b0;
            sel_q  <= 1'b1;
        end else begin
            presc  <= presc_next;
            tick_q <= tick_next;
            sel_q  <= sel_next;
        end
    end

    assign bus.count_tick  = tick_q;
    assign bus.countSelect = sel_q;

endmodule

// File: tb/tb_updown_pulse_gen.sv
// Directed bench for updown_pulse_gen with DB_CYCLES=4, DIV=8: a cycle table
// for reset and manual presses, hand sequences for auto mode and mid-run reset.
module tb_updown_pulse_gen;

    logic clk = 1'b0;
    logic clc;
    int   checks = 0;
    int   passed = 0;

    updown_pulse_gen_if bus ();

    updown_pulse_gen #(
        .DB_CYCLES(4),
        .DIV      (8)
    ) dut (
        .clk(clk),
        .clc(clc),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        logic  clc;
        logic  up;
        logic  down;
        logic  auto_r;
        logic  exp_tick;
        logic  exp_sel;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string name, logic c, logic u, logic d, logic a,
                                logic et, logic es, int n);
        vec_t v;
        v.name = name; v.clc = c; v.up = u; v.down = d; v.auto_r = a;
        v.exp_tick = et; v.exp_sel = es;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic check(string name, int idx, logic act, logic exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    endtask

    task automatic drive(logic c, logic u, logic d, logic a);
        clc = c; bus.btn_up = u; bus.btn_down = d; bus.auto_run = a;
    endtask

    task automatic step_check(string name, int idx, logic et, logic es);
        @(posedge clk);
        #1;
        check({name, "_tick"}, idx, bus.count_tick, et);
        check({name, "_sel"}, idx, bus.countSelect, es);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0);

        // reset with arbitrary inputs, then quiet idle
        add("rst", 1, 1, 0, 1, 0, 1, 1);
        add("rst", 1, 0, 1, 0, 0, 1, 1);
        add("rst", 1, 1, 1, 1, 0, 1, 1);
        add("idle", 0, 0, 0, 0, 0, 1, 20);
        // clean down press: tick at k+6
        add("dn_wait", 0, 0, 1, 0, 0, 1, 6);
        add("dn_tick", 0, 0, 1, 0, 1, 0, 1);
        add("dn_hold", 0, 0, 1, 0, 0, 0, 3);
        add("dn_rel", 0, 0, 0, 0, 0, 0, 12);
        // bouncing up press 1,0,1,1,0 then held
        add("bounce", 0, 1, 0, 0, 0, 0, 1);
        add("bounce", 0, 0, 0, 0, 0, 0, 1);
        add("bounce", 0, 1, 0, 0, 0, 0, 2);
        add("bounce", 0, 0, 0, 0, 0, 0, 1);
        add("up_wait", 0, 1, 0, 0, 0, 0, 6);
        add("up_tick", 0, 1, 0, 0, 1, 1, 1);
        add("up_hold", 0, 1, 0, 0, 0, 1, 3);
        add("up_rel", 0, 0, 0, 0, 0, 1, 12);
        // simultaneous presses cancel
        add("both", 0, 1, 1, 0, 0, 1, 12);
        add("both_rel", 0, 0, 0, 0, 0, 1, 12);
        // set direction down before auto mode
        add("dn2_wait", 0, 0, 1, 0, 0, 1, 6);
        add("dn2_tick", 0, 0, 1, 0, 1, 0, 1);
        add("dn2_hold", 0, 0, 1, 0, 0, 0, 3);
        add("dn2_rel", 0, 0, 0, 0, 0, 0, 12);

        foreach (vecs[i]) begin
            drive(vecs[i].clc, vecs[i].up, vecs[i].down, vecs[i].auto_r);
            step_check(vecs[i].name, i, vecs[i].exp_tick, vecs[i].exp_sel);
        end

        // auto mode: sync'd auto_run rises at edge 1, ticks every 8 edges;
        // up press from edge 31 gives manual tick at 37, then auto resumes 8 later
        for (int i = 0; i < 57; i++) begin
            logic et;
            et = (i == 9) || (i == 17) || (i == 25) || (i == 33) ||
                 (i == 37) || (i == 45) || (i == 53);
            drive(1'b0, i >= 31, 1'b0, 1'b1);
            step_check("auto", i, et, i >= 37);
        end

        // auto_run dropped mid-interval: no partial tick
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            step_check("auto_off", i, 1'b0, 1'b1);
        end

        // reset at edge 8 while down FSM is P_HIGH cnt=3 and prescaler is 6
        for (int i = 0; i < 26; i++) begin
            drive(i == 8, 1'b0, i >= 3, 1'b1);
            step_check("mid_rst", i, (i == 15) || (i == 23), i < 15);
        end

        drive(1'b0, 1'b0, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
